// File: rtl/fp_norm_pack_if.sv
// rtl/fp_norm_pack_if.sv - operand/result handshake bundle for fp_norm_pack
interface fp_norm_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        SR;
    logic [7:0]  ER;
    logic [27:0] MR;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    modport master (
        output in_valid, SR, ER, MR, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );

    modport slave (
        input  in_valid, SR, ER, MR, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/fp_norm_pack.sv
// rtl/fp_norm_pack.sv - single-precision normalize, round-to-nearest-even and pack
module fp_norm_pack (
    input  logic           clk,
    input  logic           rst_n,
    fp_norm_pack_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [8:0]  e_q, e_d;
    logic [27:0] m_q, m_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inx_q, inx_d;

    logic        round_up;
    logic [24:0] rnd_sum;
    logic [8:0]  rnd_e;
    logic        rnd_hidden;
    logic [22:0] rnd_frac;
    logic [7:0]  rnd_exp;
    logic        rnd_inexact;

    // Rounding works on m[27:3]; a carry into bit 27 renormalizes by one right shift.
    always_comb begin
        round_up    = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        rnd_sum     = m_q[27:3] + {24'b0, round_up};
        rnd_inexact = |m_q[2:0];
        if (rnd_sum[24]) begin
            rnd_e      = e_q + 9'd1;
            rnd_hidden = 1'b1;
            rnd_frac   = rnd_sum[23:1];
        end else begin
            rnd_e      = e_q;
            rnd_hidden = rnd_sum[23];
            rnd_frac   = rnd_sum[22:0];
        end
        rnd_exp = rnd_hidden ? rnd_e[7:0] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = NORM;
            NORM: begin
                if (m_q == 28'd0)                      state_d = DONE;
                else if (m_q[27])                      state_d = NORM;
                else if (!m_q[26] && (e_q > 9'd1))     state_d = NORM;
                else                                   state_d = ROUND;
            end
            ROUND: state_d = DONE;
            DONE:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.overflow  = ovf_q;
        bus.underflow = unf_q;
        bus.inexact   = inx_q;
    end

    always_comb begin
        s_d      = s_q;
        e_d      = e_q;
        m_d      = m_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    s_d = bus.SR;
                    e_d = (bus.ER == 8'd0) ? 9'd1 : {1'b0, bus.ER};
                    m_d = bus.MR;
                end
            end
            NORM: begin
                if (m_q == 28'd0) begin
                    result_d = {s_q, 31'b0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                end else if (m_q[27]) begin
                    // Fold the bit shifted out into sticky so rounding still sees it.
                    m_d = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
                    e_d = e_q + 9'd1;
                end else if (!m_q[26] && (e_q > 9'd1)) begin
                    m_d = m_q << 1;
                    e_d = e_q - 9'd1;
                end
            end
            ROUND: begin
                e_d = rnd_e;
                if (rnd_e >= 9'd255) begin
                    result_d = {s_q, 8'hFF, 23'b0};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {s_q, rnd_exp, rnd_frac};
                    ovf_d    = 1'b0;
                    unf_d    = (rnd_exp == 8'h00) && (rnd_frac != 23'd0) && rnd_inexact;
                    inx_d    = rnd_inexact;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= 1'b0;
            e_q      <= 9'd0;
            m_q      <= 28'd0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            s_q      <= s_d;
            e_q      <= e_d;
            m_q      <= m_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end
endmodule

// File: tb/tb_fp_norm_pack.sv
// tb/tb_fp_norm_pack.sv - scoreboard bench for fp_norm_pack
module tb_fp_norm_pack;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_norm_pack_if bus();

    fp_norm_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;   // {overflow, underflow, inexact}
        int          lat;   // edges counted with the accepting edge as edge 1
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_bad = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] held_res = 32'd0;
    logic [2:0]  held_flg = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            check("ready_valid_exclusive", 32'(bus.in_ready & bus.out_valid), 32'd0);
            if (bus.out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("result", bus.result, sb[0].res);
                    check("flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'(sb[0].flg));
                    check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                    sb.delete(0);
                end
                held_res <= bus.result;
                held_flg <= {bus.overflow, bus.underflow, bus.inexact};
            end else if (bus.out_valid) begin
                check("hold_result", bus.result, held_res);
                check("hold_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'(held_flg));
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            prev_valid <= bus.out_valid;
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic sr, input logic [7:0] er, input logic [27:0] mr,
                        input logic [31:0] res, input logic [2:0] flg, input int lat, input int junk);
        exp_t it;
        wait_ready();
        bus.SR = sr;
        bus.ER = er;
        bus.MR = mr;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        it.res = res;
        it.flg = flg;
        it.lat = lat;
        it.acc = cyc;
        sb.push_back(it);
        for (int j = 0; j < junk; j++) begin
            bus.SR = ~sr;
            bus.ER = 8'hAA;
            bus.MR = 28'h5555555;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.SR        = 1'b0;
        bus.ER        = 8'd0;
        bus.MR        = 28'd0;
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, 8'd127, 28'h4000000, 32'h3F800000, 3'b000, 3, 0);
        send(1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000, 4, 0);
        send(1'b0, 8'd127, 28'h1000000, 32'h3E800000, 3'b000, 5, 2);
        send(1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b001, 3, 0);
        send(1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001, 3, 0);
        send(1'b0, 8'd254, 28'h8000000, 32'h7F800000, 3'b101, 4, 0);
        send(1'b0, 8'd1,   28'h2000000, 32'h00400000, 3'b000, 3, 0);
        send(1'b0, 8'd0,   28'h2000000, 32'h00400000, 3'b000, 3, 0);
        send(1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 3'b001, 3, 0);
        send(1'b0, 8'd1,   28'h0000006, 32'h00000001, 3'b011, 3, 0);
        send(1'b1, 8'd255, 28'h4000000, 32'hFF800000, 3'b101, 3, 0);
        send(1'b1, 8'd128, 28'h4000000, 32'hC0000000, 3'b000, 3, 0);
        send(1'b0, 8'd127, 28'h8000009, 32'h40000001, 3'b001, 4, 0);

        // Zero result under backpressure.
        wait_ready();
        bus.out_ready = 1'b0;
        send(1'b1, 8'd127, 28'h0000000, 32'h80000000, 3'b000, 2, 0);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (5) @(negedge clk);
        check("bp_still_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Reset in the middle of a long NORM sequence; nothing may come out.
        wait_ready();
        bus.SR = 1'b0;
        bus.ER = 8'd127;
        bus.MR = 28'h0000010;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_norm_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("async_reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b0, 8'd127, 28'h0000010, 32'h34800000, 3'b000, 25, 0);
        send(1'b0, 8'd127, 28'h4000000, 32'h3F800000, 3'b000, 3, 0);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_norm_pack.md
FP_NORM_PACK -- requirements
Module: fp_norm_pack

Interface
REQ-001 Parameters: none; widths fixed for IEEE-754 single precision.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand present.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 SR  input  1  result sign.
REQ-007 ER  input  8  biased exponent of the sum; 0 is treated as 1, and 255 is treated as overflow.
REQ-008 MR  input  28  sum mantissa: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  32  packed single {sign, exp[7:0], frac[22:0]}.
REQ-012 overflow, underflow, inexact  output  1 each  exception flags, valid while out_valid=1.

Function
REQ-013 FSM states and outputs:
- IDLE: in_ready=1.
- NORM: in_ready=0.
- ROUND: in_ready=0.
- DONE: out_valid=1.
- All other outputs are held in registers.
REQ-014 IDLE: on in_valid=1, capture SR, ER and MR into s, e and m, then go to NORM. The internal exponent e is 9 bits; ER=0 loads 1.
REQ-015 NORM performs exactly one action per cycle, in this priority order:
- m==0: go to DONE with zero result {s,31'b0} and all flags 0.
- m[27]=1: m becomes {0,m[27:1]} with m[0]=old m[1]|old m[0] (sticky is preserved); e=e+1; stay in NORM.
- m[26]=0 and e>1: m=m<<1; e=e-1; stay in NORM.
- Otherwise go to ROUND.
REQ-016 ROUND uses round-to-nearest-even:
- Increment m[27:3] when m[2] & (m[1] | m[0] | m[3]).
- If the increment carries into m[27], shift right once and set e=e+1.
- inexact = m[2] | m[1] | m[0] before rounding.
REQ-017 Packing:
- Exponent field = m[26] ? e[7:0] : 8'h00 (subnormal).
- Fraction = m[25:3].
- A subnormal that rounds up into m[26] packs with exponent 1.
REQ-018 Overflow: if e>=255 after ROUND, result={s,8'hFF,23'b0}, overflow=1, inexact=1.
REQ-019 underflow = 1 when the exponent field is 0, the result is non-zero, and inexact=1.
REQ-020 Latency: with k NORM shifts, out_valid rises on the (k+3)th rising edge after the accepting edge. A zero input takes 2 edges.
REQ-021 DONE holds result and flags stable while out_ready=0. When out_ready=1, go to IDLE on that edge; out_valid=0 and in_ready=1 in the next cycle.
REQ-022 Handshakes:
- in_ready and out_valid are never both 1.
- in_valid while busy is ignored, and the block does not sample it.
- Only one operation is in flight; there is no input buffering.

Reset
REQ-023 When rst_n=0, the block goes to IDLE immediately, independent of clk.
REQ-024 Reset values: in_ready=1 (out of reset), out_valid=0, result=0, all flags=0, internal s/e/m=0.
REQ-025 Reset in any state, including mid-NORM, discards the in-flight operation; no out_valid follows it.

Verification
REQ-026 SR=0, ER=127, MR=28'h4000000 -> result 32'h3F800000, flags 0, out_valid 3 edges after accept.
REQ-027 Normalization in both directions:
- ER=127, MR=28'h8000000 -> 32'h40000000 after 4 edges.
- ER=127, MR=28'h1000000 -> 32'h3E800000 after 5 edges.
REQ-028 Round-to-even, ER=127:
- MR=28'h4000004 (tie, LSB even) -> 32'h3F800000, inexact=1.
- MR=28'h400000C (tie, LSB odd) -> 32'h3F800002, inexact=1.
REQ-029 Overflow and subnormal:
- ER=254, MR=28'h8000000 -> 32'h7F800000, overflow=1, inexact=1.
- ER=1, MR=28'h2000000 -> 32'h00400000, flags 0.
REQ-030 Zero and backpressure: SR=1, MR=0 -> 32'h80000000, flags 0. Holding out_ready=0 for 5 cycles keeps result and out_valid stable with in_ready=0.
REQ-031 Reset during NORM (MR=28'h0000010) -> out_valid=0 and in_ready=1 immediately. The next operand then completes correctly.
